sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single request port of the SDRAM controller between NREQ requesters (e.g. capture writer, USB reader).
- Round-robin arbitration on the request side.
- Records the owner of every accepted request in an in-order tag FIFO.
- Steers the controller's in-order completions (bvalid/bwe/bdata) back to the owning requester.
- Sits directly between the requesters and the SDRAM controller's avalid/aready port.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TAG_DEPTH, 8, outstanding-request tag FIFO depth (power of 2, >= 4).
- MAX_LOCK, 16, max consecutive grants under row lock (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*24  flattened word addresses; requester k at [24k+23:24k].
- req_data  in  NREQ*16  flattened write data.
- rsp_valid  out  NREQ  completion strobe, one-hot.
- rsp_we  out  1  completion type (1 = write ack, 0 = read data).
- rsp_data  out  16  read data, shared by all requesters.
- m_avalid  out  1  to controller.
- m_aready  in  1  from controller.
- m_awe  out  1  to controller.
- m_aaddr  out  24  to controller.
- m_adata  out  16  to controller.
- m_bvalid  in  1  controller completion.
- m_bwe  in  1  controller completion type.
- m_bdata  in  16  controller read data.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: rsp_valid = 0, rsp_we = 0, rsp_data = 0, err = 0; rr pointer = 0; lock flag clear; tag FIFO empty.
- Request path is combinational, zero latency. sel = first requester with req_valid set, searching from rr pointer upward with wrap.
- m_avalid = |req_valid && !tag_full. m_awe, m_aaddr, m_adata mux from sel.
- req_ready[k] = (sel == k) && m_aready && !tag_full.
- Hold rule: if m_avalid=1 and m_aready=0, register sel and set the lock flag. While locked, sel is frozen even if other requesters raise valid. Lock clears on the accepting edge.
- Transfer = m_avalid && m_aready. On transfer:
  - push sel into the tag FIFO;
  - rr pointer <= sel+1 (mod NREQ).
- Tag FIFO full: m_avalid forced 0 and all req_ready = 0 until a pop. Accept the push when a pop occurs in the same cycle.
- Response path, one registered stage. On m_bvalid:
  - rsp_valid[head] <= 1, rsp_we <= m_bwe, rsp_data <= m_bdata;
  - pop the tag FIFO.
  - Otherwise rsp_valid <= 0; rsp_we and rsp_data hold.
- Simultaneous push and pop: count unchanged, both pointers advance.
- m_bvalid with the FIFO empty: set err (sticky until rst), drop the response, no pop.
- Pointer and count wrap is mod TAG_DEPTH; count width is clog2(TAG_DEPTH)+1.
- Requester drops req_valid while locked: lock released next cycle, rr pointer unchanged (protocol violation, no error flagged).
- Reset mid-operation: tags are lost. The controller is reset by the same rst, so no stale completions are expected.

Optional Feature:
- Macro SDRAM_ARB_ROW_LOCK_EN.
- Defined:
  - Store bank+row (addr[23:9]) of the last transfer and the owner.
  - If the owner's current request matches that bank+row and lock_cnt < MAX_LOCK, the owner wins over round-robin and the rr pointer is not advanced.
  - lock_cnt increments per locked grant and resets to 0 on any grant to a different requester or on a row change.
- Undefined: pure round-robin; no row registers or lock_cnt are synthesized.

Decomposition:
- Package sdram_pkg holds:
  - SDRAM_ADDR_W = 24, SDRAM_DATA_W = 16;
  - row/bank/column field positions (col [8:0], bank [10:9], row [23:11]);
  - the tag width function.
- One sub-module, sdram_arb_tagfifo:
  - synchronous FIFO of clog2(NREQ)-bit owner tags;
  - ports: push, pop, din, dout, full, empty.

Test Plan:
- Single requester: r0 writes addr 0x000010 data 0xA5A5 with m_aready=1, controller returns m_bvalid, m_bwe=1 one cycle later → rsp_valid=01, rsp_we=1 one cycle after that; err=0.
- Round-robin: r0 and r1 both hold valid, m_aready=1 continuously → grants alternate r0,r1,r0,r1; each requester gets 50%.
- Hold: m_aready=0 for 3 cycles while r0 is selected and r1 raises valid → m_aaddr stays at r0's address; r0 is accepted first, then r1.
- Read routing: r1 reads, r0 writes; controller returns the write ack, then read data 0x1234 three cycles later → rsp_valid=01 (we=1) then rsp_valid=10 with rsp_data=0x1234.
- Full: withhold m_bvalid after 8 accepted requests → m_avalid=0 and req_ready=0; one m_bvalid re-enables acceptance in the same cycle.
- Error: inject m_bvalid with the FIFO empty → err=1 and stays 1 until rst. With SDRAM_ARB_ROW_LOCK_EN and r0 streaming same-row addresses → r0 gets 16 consecutive grants, then r1 is granted.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM address and data widths, address field positions and tag sizing
// for the SDRAM request arbiter.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 16;

  localparam int COL_LSB  = 0;
  localparam int COL_MSB  = 8;
  localparam int BANK_LSB = 9;
  localparam int BANK_MSB = 10;
  localparam int ROW_LSB  = 11;
  localparam int ROW_MSB  = 23;

  // Owner tag width; a single-bit tag is kept even for the two-requester case.
  function automatic int tag_width(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sdram_arb_tagfifo.sv
// In-order FIFO of requester owner tags, one entry per request accepted by the
// SDRAM controller and not yet completed. A push into a full FIFO is taken when a pop coincides.
module sdram_arb_tagfifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is read combinationally so a completion can be steered in its own cycle.
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request port between NREQ
// requesters, routing in-order completions back by owner tag. Optional macro: SDRAM_ARB_ROW_LOCK_EN.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int TAG_DEPTH = 8,
  parameter int MAX_LOCK  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ*SDRAM_ADDR_W-1:0]   req_addr,
  input  logic [NREQ*SDRAM_DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]                rsp_valid,
  output logic                           rsp_we,
  output logic [SDRAM_DATA_W-1:0]        rsp_data,
  output logic                           m_avalid,
  input  logic                           m_aready,
  output logic                           m_awe,
  output logic [SDRAM_ADDR_W-1:0]        m_aaddr,
  output logic [SDRAM_DATA_W-1:0]        m_adata,
  input  logic                           m_bvalid,
  input  logic                           m_bwe,
  input  logic [SDRAM_DATA_W-1:0]        m_bdata,
  output logic                           err
);

  localparam int TW = tag_width(NREQ);

  if (NREQ < 2 || NREQ > 4 || TAG_DEPTH < 4 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || MAX_LOCK < 1)
  begin : g_bad_cfg
    $error("sdram_arbiter: unsupported parameter set");
  end

  logic [SDRAM_ADDR_W-1:0] addr_arr [NREQ];
  logic [SDRAM_DATA_W-1:0] data_arr [NREQ];
  logic [NREQ-1:0]         head_onehot;
  logic [TW-1:0]           rr_ptr_reg;
  logic                    lock_reg;
  logic [TW-1:0]           lock_sel_reg;
  logic [TW-1:0]           rr_sel;
  logic [TW-1:0]           cand;
  logic                    found;
  logic [TW-1:0]           pick;
  logic [TW-1:0]           sel;
  logic                    rr_advance;
  logic                    xfer;
  logic                    blocked;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [TW-1:0]           head;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign addr_arr[gi]    = req_addr[gi*SDRAM_ADDR_W +: SDRAM_ADDR_W];
    assign data_arr[gi]    = req_data[gi*SDRAM_DATA_W +: SDRAM_DATA_W];
    assign req_ready[gi]   = (sel == TW'(gi)) && m_aready && !blocked;
    assign head_onehot[gi] = (head == TW'(gi));
  end

  always_comb begin
    rr_sel = rr_ptr_reg;
    cand   = rr_ptr_reg;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[cand]) begin
        rr_sel = cand;
        found  = 1'b1;
      end
      cand = (cand == TW'(NREQ-1)) ? '0 : cand + 1'b1;
    end
  end

`ifdef SDRAM_ARB_ROW_LOCK_EN
  localparam int BR_W  = ROW_MSB - BANK_LSB + 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [BR_W-1:0]  row_reg;
  logic [TW-1:0]    owner_reg;
  logic             owner_vld_reg;
  logic [CNT_W-1:0] lock_cnt_reg;
  logic             row_win;
  logic             same_row;

  assign same_row   = owner_vld_reg && (sel == owner_reg) &&
                      (addr_arr[sel][ROW_MSB:BANK_LSB] == row_reg);
  assign row_win    = owner_vld_reg && req_valid[owner_reg] &&
                      (addr_arr[owner_reg][ROW_MSB:BANK_LSB] == row_reg) &&
                      (lock_cnt_reg < CNT_W'(MAX_LOCK));
  assign pick       = row_win ? owner_reg : rr_sel;
  assign rr_advance = !(row_win && (sel == owner_reg));

  // lock_cnt counts grants in the current same-row run, including the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg       <= '0;
      owner_reg     <= '0;
      owner_vld_reg <= 1'b0;
      lock_cnt_reg  <= '0;
    end else if (xfer) begin
      row_reg       <= addr_arr[sel][ROW_MSB:BANK_LSB];
      owner_reg     <= sel;
      owner_vld_reg <= 1'b1;
      lock_cnt_reg  <= same_row ? lock_cnt_reg + 1'b1 : CNT_W'(1);
    end
  end
`else
  assign pick       = rr_sel;
  assign rr_advance = 1'b1;
`endif

  assign sel      = lock_reg ? lock_sel_reg : pick;
  assign blocked  = fifo_full && !m_bvalid;
  // Gated by the selected requester so a requester that drops valid under hold issues nothing.
  assign m_avalid = req_valid[sel] && !blocked;
  assign m_awe    = req_we[sel];
  assign m_aaddr  = addr_arr[sel];
  assign m_adata  = data_arr[sel];
  assign xfer     = m_avalid && m_aready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_sel_reg <= '0;
    end else begin
      lock_reg <= m_avalid && !m_aready;
      if (m_avalid && !m_aready) lock_sel_reg <= sel;
      if (xfer && rr_advance) rr_ptr_reg <= (sel == TW'(NREQ-1)) ? '0 : sel + 1'b1;
    end
  end

  sdram_arb_tagfifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TW)
  ) u_tagfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .pop   (m_bvalid),
    .din   (sel),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_we    <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else if (m_bvalid && !fifo_empty) begin
      rsp_valid <= head_onehot;
      rsp_we    <= m_bwe;
      rsp_data  <= m_bdata;
    end else begin
      rsp_valid <= '0;
      if (m_bvalid) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the arbiter.
module tb_sdram_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [47:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  rsp_valid;
  logic        rsp_we;
  logic [15:0] rsp_data;
  logic        m_avalid;
  logic        m_aready;
  logic        m_awe;
  logic [23:0] m_aaddr;
  logic [15:0] m_adata;
  logic        m_bvalid;
  logic        m_bwe;
  logic [15:0] m_bdata;
  logic        err;

  int          total;
  int          bad;
  int          tags[$];
  int          rr;
  int          held;
  logic [1:0]  exp_rv;
  logic        exp_we;
  logic [15:0] exp_data;
  logic        exp_err;
  int          obs_grants[2];

  sdram_arbiter #(.NREQ(NREQ), .TAG_DEPTH(DEPTH), .MAX_LOCK(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_we    (rsp_we),
    .rsp_data  (rsp_data),
    .m_avalid  (m_avalid),
    .m_aready  (m_aready),
    .m_awe     (m_awe),
    .m_aaddr   (m_aaddr),
    .m_adata   (m_adata),
    .m_bvalid  (m_bvalid),
    .m_bwe     (m_bwe),
    .m_bdata   (m_bdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input bit v, input bit we,
                         input logic [23:0] a, input logic [15:0] d);
    req_valid[k]         = v;
    req_we[k]            = we;
    req_addr[k*24 +: 24] = a;
    req_data[k*16 +: 16] = d;
  endtask

  task automatic model_reset();
    tags.delete();
    rr       = 0;
    held     = -1;
    exp_rv   = '0;
    exp_we   = 1'b0;
    exp_data = '0;
    exp_err  = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_data  = '0;
    m_aready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bwe     = 1'b0;
    m_bdata   = '0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_we", rsp_we, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_err", err, 0);
    chk("reset_avalid", m_avalid, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: inputs were set at the preceding negedge.
  task automatic tick();
    int  g;
    bit  blocked;
    bit  exp_av;
    int  head;
    bit  had_tag;
    #1;
    blocked = (tags.size() == DEPTH) && !m_bvalid;
    g = -1;
    if (held >= 0) g = held;
    else for (int i = 0; i < NREQ; i++) if (g < 0 && req_valid[(rr + i) % NREQ]) g = (rr + i) % NREQ;
    exp_av = (g >= 0) && req_valid[g] && !blocked;
    chk("m_avalid", m_avalid, exp_av);
    if (exp_av) begin
      chk("m_aaddr", m_aaddr, req_addr[g*24 +: 24]);
      chk("m_awe", m_awe, req_we[g]);
      chk("m_adata", m_adata, req_data[g*16 +: 16]);
      chk("req_ready", req_ready, m_aready ? (32'd1 << g) : 32'd0);
    end else if (blocked) begin
      chk("req_ready_full", req_ready, 0);
    end
    if (m_aready)
      for (int k = 0; k < NREQ; k++) if (req_ready[k] && req_valid[k]) obs_grants[k]++;
    had_tag = tags.size() > 0;
    head = 0;
    if (m_bvalid && had_tag) head = tags.pop_front();
    if (exp_av && m_aready) begin
      tags.push_back(g);
      rr   = (g + 1) % NREQ;
      held = -1;
    end else begin
      held = exp_av ? g : -1;
    end
    if (m_bvalid && had_tag) begin
      exp_rv   = 2'(1 << head);
      exp_we   = m_bwe;
      exp_data = m_bdata;
    end else begin
      exp_rv = '0;
      if (m_bvalid) exp_err = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_we", rsp_we, exp_we);
    chk("rsp_data", rsp_data, exp_data);
    chk("err", err, exp_err);
    @(negedge clk);
  endtask

  task automatic drain();
    req_valid = '0;
    for (int i = 0; i < DEPTH + 2 && tags.size() > 0; i++) begin
      m_bvalid = 1'b1;
      m_bwe    = 1'b1;
      m_bdata  = 16'(i);
      tick();
    end
    m_bvalid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    obs_grants[0] = 0;
    obs_grants[1] = 0;
    @(negedge clk);
    do_reset();

    // Single write from r0, acknowledged one cycle later.
    set_req(0, 1, 1, 24'h000010, 16'hA5A5);
    m_aready = 1'b1;
    tick();
    set_req(0, 0, 0, 24'h0, 16'h0);
    m_bvalid = 1'b1; m_bwe = 1'b1; m_bdata = 16'h0000;
    tick();
    chk("single_rsp_onehot", rsp_valid, 2'b01);
    m_bvalid = 1'b0;
    tick();

    // Round-robin: both requesters valid, controller always ready.
    obs_grants[0] = 0;
    obs_grants[1] = 0;
    set_req(0, 1, 0, 24'h000100, 16'h1111);
    set_req(1, 1, 1, 24'h800200, 16'h2222);
    for (int i = 0; i < 6; i++) begin
      m_bvalid = tags.size() > 0;
      m_bwe    = 1'b0;
      m_bdata  = 16'(16'h4000 + i);
      tick();
    end
    chk("rr_grants_r0", obs_grants[0], 3);
    chk("rr_grants_r1", obs_grants[1], 3);
    drain();

    // Hold: controller stalls while r0 is selected and r1 joins.
    m_aready = 1'b0;
    set_req(0, 1, 1, 24'h0ABCDE, 16'h5555);
    set_req(1, 0, 0, 24'h0, 16'h0);
    tick();
    set_req(1, 1, 0, 24'h123456, 16'h6666);
    tick();
    tick();
    chk("hold_addr", m_aaddr, 24'h0ABCDE);
    m_aready = 1'b1;
    tick();
    set_req(0, 0, 0, 24'h0, 16'h0);
    tick();
    set_req(1, 0, 0, 24'h0, 16'h0);
    drain();

    // Read routing: r0 write then r1 read; completions return in order.
    set_req(0, 1, 1, 24'h000040, 16'hBEEF);
    tick();
    set_req(0, 0, 0, 24'h0, 16'h0);
    set_req(1, 1, 0, 24'h000080, 16'h0);
    tick();
    set_req(1, 0, 0, 24'h0, 16'h0);
    m_bvalid = 1'b1; m_bwe = 1'b1; m_bdata = 16'h0000;
    tick();
    m_bvalid = 1'b0;
    tick();
    tick();
    m_bvalid = 1'b1; m_bwe = 1'b0; m_bdata = 16'h1234;
    tick();
    chk("read_route_valid", rsp_valid, 2'b10);
    chk("read_route_data", rsp_data, 16'h1234);
    m_bvalid = 1'b0;
    tick();

    // Full: eight outstanding requests block the port until a completion.
    set_req(0, 1, 1, 24'h000300, 16'h7777);
    for (int i = 0; i < DEPTH; i++) tick();
    tick();
    chk("full_avalid", m_avalid, 0);
    m_bvalid = 1'b1; m_bwe = 1'b1; m_bdata = 16'h0001;
    tick();
    m_bvalid = 1'b0;
    set_req(0, 0, 0, 24'h0, 16'h0);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
      set_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
      m_aready = ($urandom_range(0, 3) != 0);
      m_bvalid = (tags.size() > 0) && ($urandom_range(0, 2) != 0);
      m_bwe    = 1'($urandom_range(0, 1));
      m_bdata  = 16'($urandom);
      tick();
    end
    drain();

    // Error: completion with nothing outstanding; sticky until reset.
    m_bvalid = 1'b1; m_bwe = 1'b0; m_bdata = 16'hDEAD;
    tick();
    m_bvalid = 1'b0;
    tick();
    tick();
    chk("err_sticky", err, 1);
    do_reset();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
